fp_norm_round: RTL and testbench



---
 rtl/fp_norm_round.sv | 110 +++++++++++
 tb/tb_fp_norm_round.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// fp_norm_round: post-add normalise (one bit per cycle), round-to-nearest-even and IEEE-754 single packing
// with valid/ready handshakes on both sides.
module fp_norm_round #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_special,
    input  logic [31:0]       in_special_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              overflow
);
    localparam int XW = EXP_W + 2;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic signed [XW-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0]     mant_q, mant_d;
    logic [31:0]           result_q, result_d;
    logic                  overflow_q, overflow_d;
    logic                  up;
    logic [24:0]           r25;
    logic [22:0]           frac;
    logic signed [XW-1:0]  field;
    logic [MANT_W-1:0]     mant_rsh;

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        mant_rsh   = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
        up         = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        r25        = mant_q[27:3] + 25'(up);
        frac       = r25[24] ? r25[23:1] : r25[22:0];
        // a denormal that rounds into the hidden bit already sits at exp 1
        field      = r25[24] ? exp_q + XW'(1) : (r25[23] ? exp_q : '0);
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d     = in_sign;
                exp_d      = {{2{in_exp[EXP_W-1]}}, in_exp};
                mant_d     = in_mant;
                result_d   = in_special_val;
                overflow_d = 1'b0;
                state_d    = in_special ? OUT : NORM;
            end
            NORM: if (mant_q == '0) begin
                result_d   = {sign_q, 31'b0};
                overflow_d = 1'b0;
                state_d    = OUT;
            end else if (mant_q[27]) begin
                mant_d = mant_rsh;
                exp_d  = exp_q + XW'(1);
            end else if (exp_q < XW'(-27)) begin
                mant_d = {{(MANT_W-1){1'b0}}, |mant_q};
                exp_d  = XW'(1);
            end else if (exp_q < XW'(1)) begin
                mant_d = mant_rsh;
                exp_d  = exp_q + XW'(1);
            end else if (!mant_q[26] && exp_q > XW'(1)) begin
                mant_d = {mant_q[MANT_W-2:0], 1'b0};
                exp_d  = exp_q - XW'(1);
            end else begin
                state_d = ROUND;
            end
            ROUND: begin
                overflow_d = field >= XW'(255);
                result_d   = overflow_d ? {sign_q, 8'hFF, 23'b0} : {sign_q, field[7:0], frac};
                state_d    = OUT;
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign result    = result_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed vectors with hand-computed IEEE-754 results, latencies,
// backpressure and mid-operation reset for fp_norm_round.
module tb_fp_norm_round;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_sign = 1'b0;
    logic        in_special = 1'b0, out_ready = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic [31:0] in_special_val = '0;
    logic        in_ready, out_valid, overflow;
    logic [31:0] result;
    int          checks = 0, errors = 0;

    fp_norm_round dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_special(in_special), .in_special_val(in_special_val),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic issue(input logic s, input int e, input logic [27:0] m,
                         input logic sp, input logic [31:0] sv, output int lat);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1; in_sign = s; in_exp = 10'(e); in_mant = m;
        in_special = sp; in_special_val = sv;
        @(posedge clk); #1;
        in_valid = 1'b0; in_special = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic s, input int e, input logic [27:0] m,
                       input logic sp, input logic [31:0] sv,
                       input logic [31:0] want_res, input logic want_ovf, input int want_lat);
        int lat;
        issue(s, e, m, sp, sv, lat);
        chk({tag, " latency"}, 32'(lat), 32'(want_lat));
        chk({tag, " result"}, result, want_res);
        chk({tag, " overflow"}, 32'(overflow), 32'(want_ovf));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat, seen;
        #12 reset = 1'b0;
        @(posedge clk); #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'h0);
        chk("reset overflow", 32'(overflow), 32'd0);

        run("one",       0, 127,  28'h4000000, 0, 32'h0, 32'h3F800000, 0, 3);
        run("carry",     0, 127,  28'h8000000, 0, 32'h0, 32'h40000000, 0, 4);
        run("cancel",    0, 127,  28'h0000008, 0, 32'h0, 32'h34000000, 0, 26);
        run("tie_even",  0, 127,  28'h4000004, 0, 32'h0, 32'h3F800000, 0, 3);
        run("tie_up",    0, 127,  28'h400000C, 0, 32'h0, 32'h3F800002, 0, 3);
        run("ovf",       0, 254,  28'h7FFFFFC, 0, 32'h0, 32'h7F800000, 1, 3);
        run("neg_zero",  1, 127,  28'h0000000, 0, 32'h0, 32'h80000000, 0, 2);
        run("neg_three", 1, 128,  28'h6000000, 0, 32'h0, 32'hC0400000, 0, 3);
        run("denorm",    0, -1,   28'h4000000, 0, 32'h0, 32'h00200000, 0, 5);
        run("collapse",  0, -200, 28'h4000001, 0, 32'h0, 32'h00000000, 0, 4);
        run("special",   0, 127,  28'h4000000, 1, 32'h7FC00000, 32'h7FC00000, 0, 1);

        // hold the result under backpressure while upstream tries to issue again
        issue(0, 127, 28'h4000000, 0, 32'h0, lat);
        chk("bp latency", 32'(lat), 32'd3);
        in_valid = 1'b1; in_mant = 28'h8000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp result", result, 32'h3F800000);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("idle out_ready high", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // abort a long normalisation with an asynchronous reset
        in_valid = 1'b1; in_sign = 0; in_exp = 10'd127; in_mant = 28'h0000008;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort result", result, 32'h0);
        chk("abort overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort no output", 32'(seen), 32'd0);

        run("recover",   0, 127,  28'h4000000, 0, 32'h0, 32'h3F800000, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
